// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM blocks.
// Defaults target a 50 MHz system clock.
package servo_pkg;

    localparam int DEF_MIN_PULSE = 64;
    localparam int DEF_CLK_DIV   = 391;
    localparam int DEF_SLEW      = 0;

    // A one-entry index still needs a one-bit select port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servo_prescaler.sv
// Divides the system clock into a one-cycle tick every CLK_DIV clocks.
// With CLK_DIV=1 the tick is high every cycle.
module servo_prescaler
    import servo_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int PW = clog2_min1(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM with double-buffered duty, period-boundary
// commit and optional per-period slew limiting.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int DUTY_W    = 8,
    parameter int CNT_W     = 12,
    parameter int MIN_PULSE = DEF_MIN_PULSE,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int SLEW      = DEF_SLEW,
    localparam int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    chan_sel,
    input  logic [DUTY_W-1:0]   duty_in,
    input  logic [CHANNELS-1:0] en_in,
    input  logic [CNT_W-1:0]    endcount,
    input  logic                commit,
    output logic                pending,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm_out
);

    logic                tick;
    logic                boundary;
    logic                apply;
    logic [CNT_W-1:0]    counter;
    logic [CNT_W-1:0]    endcount_l;
    logic [CHANNELS-1:0] enable_l;

    servo_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // >= keeps the counter bounded when endcount is lowered mid-period.
    assign boundary = tick && (counter >= endcount_l);
    assign apply    = boundary && pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            counter      <= '0;
            endcount_l   <= endcount;
            enable_l     <= '0;
            pending      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (tick) begin
                counter <= boundary ? '0 : counter + CNT_W'(1);
            end
            // A commit landing on the boundary cycle waits a full period.
            pending      <= commit || (pending && !boundary);
            period_start <= boundary;
            if (apply) begin
                enable_l   <= en_in;
                endcount_l <= endcount;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DUTY_W-1:0] staging;
        logic [DUTY_W-1:0] target;
        logic [DUTY_W-1:0] active;
        logic [DUTY_W-1:0] next_active;
        logic [CNT_W:0]    thresh;
        logic              pwm_q;

        if (SLEW == 0) begin : g_jump
            assign next_active = pending ? staging : target;
        end else begin : g_slew
            logic              up;
            logic [DUTY_W-1:0] diff;
            logic [DUTY_W-1:0] step;
            always_comb begin
                up          = (target >= active);
                diff        = up ? target - active : active - target;
                step        = (32'(diff) > SLEW) ? DUTY_W'(SLEW) : diff;
                next_active = up ? active + step : active - step;
            end
        end

        assign thresh = (CNT_W+1)'(MIN_PULSE) + (CNT_W+1)'(active);

        always_ff @(posedge clock) begin
            if (reset) begin
                staging <= '0;
                target  <= '0;
                active  <= '0;
                pwm_q   <= 1'b0;
            end else begin
                if (wr_en && chan_sel == SEL_W'(i)) begin
                    staging <= duty_in;
                end
                if (apply) begin
                    target <= staging;
                end
                if (boundary) begin
                    active <= next_active;
                end
                pwm_q <= enable_l[i] && ({1'b0, counter} < thresh);
            end
        end

        assign pwm_out[i] = pwm_q;
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Scoreboard bench: stimulus queues per-period pulse widths, a monitor
// measures each output period and compares it against the queue.
module tb_servo_pwm_bank;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]       dut;
        logic [15:0]      idx;
        logic [15:0]      len;
        logic [3:0][15:0] hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    // DUT A: 4 channels, no prescale, no slew
    logic        rst1 = 1'b1, wr1 = 1'b0, commit1 = 1'b0;
    logic [1:0]  sel1 = '0;
    logic [7:0]  duty1 = '0;
    logic [3:0]  en1 = '0;
    logic [11:0] end1 = 12'd99;
    logic        pend1, ps1;
    logic [3:0]  pwm1;

    // DUT B: 3 channels, slew 4
    logic        rst2 = 1'b1, wr2 = 1'b0, commit2 = 1'b0;
    logic [1:0]  sel2 = '0;
    logic [7:0]  duty2 = '0;
    logic [2:0]  en2 = '0;
    logic [11:0] end2 = 12'd99;
    logic        pend2, ps2;
    logic [2:0]  pwm2;

    // DUT C: 4 channels, prescaler 391
    logic        rst3 = 1'b1, wr3 = 1'b0, commit3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [7:0]  duty3 = '0;
    logic [3:0]  en3 = '0;
    logic [11:0] end3 = 12'd3;
    logic        pend3, ps3;
    logic [3:0]  pwm3;

    servo_pwm_bank #(.CHANNELS(4), .CLK_DIV(1), .SLEW(0)) dut_a (
        .clock(clock), .reset(rst1), .wr_en(wr1), .chan_sel(sel1),
        .duty_in(duty1), .en_in(en1), .endcount(end1), .commit(commit1),
        .pending(pend1), .period_start(ps1), .pwm_out(pwm1)
    );

    servo_pwm_bank #(.CHANNELS(3), .CLK_DIV(1), .SLEW(4)) dut_b (
        .clock(clock), .reset(rst2), .wr_en(wr2), .chan_sel(sel2),
        .duty_in(duty2), .en_in(en2), .endcount(end2), .commit(commit2),
        .pending(pend2), .period_start(ps2), .pwm_out(pwm2)
    );

    servo_pwm_bank #(.CHANNELS(4), .CLK_DIV(391), .SLEW(0)) dut_c (
        .clock(clock), .reset(rst3), .wr_en(wr3), .chan_sel(sel3),
        .duty_in(duty3), .en_in(en3), .endcount(end3), .commit(commit3),
        .pending(pend3), .period_start(ps3), .pwm_out(pwm3)
    );

    logic [3:0] pwm_w [3];
    logic       ps_w  [3];
    logic       rst_w [3];
    assign pwm_w[0] = pwm1;
    assign pwm_w[1] = {1'b0, pwm2};
    assign pwm_w[2] = pwm3;
    assign ps_w[0]  = ps1;
    assign ps_w[1]  = ps2;
    assign ps_w[2]  = ps3;
    assign rst_w[0] = rst1;
    assign rst_w[1] = rst2;
    assign rst_w[2] = rst3;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_win(input int d, input int idx, input int len,
                              input int h0, input int h1,
                              input int h2, input int h3);
        exp_t e;
        e.dut   = d[1:0];
        e.idx   = idx[15:0];
        e.len   = len[15:0];
        e.hi[0] = h0[15:0];
        e.hi[1] = h1[15:0];
        e.hi[2] = h2[15:0];
        e.hi[3] = h3[15:0];
        sb.push_back(e);
    endtask

    // A window spans the cycles after one period_start up to and
    // including the next; pwm_out lags the counter by one clock.
    int started [3];
    int pnum    [3];
    int len_c   [3];
    int hi_c    [3][4];

    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_w[d]) begin
                started[d] = 0;
                pnum[d]    = 0;
                len_c[d]   = 0;
                for (int c = 0; c < 4; c++) hi_c[d][c] = 0;
            end else begin
                len_c[d]++;
                for (int c = 0; c < 4; c++)
                    if (pwm_w[d][c]) hi_c[d][c]++;
                if (ps_w[d]) begin
                    if (started[d] != 0) begin
                        while (sb.size() > 0 && int'(sb[0].dut) == d &&
                               int'(sb[0].idx) < pnum[d]) begin
                            mon_e = sb.pop_front();
                            chk($sformatf("missed_d%0d_w%0d", d, mon_e.idx),
                                32'(pnum[d]), 32'(mon_e.idx));
                        end
                        if (sb.size() > 0 && int'(sb[0].dut) == d &&
                            int'(sb[0].idx) == pnum[d]) begin
                            mon_e = sb.pop_front();
                            chk($sformatf("len_d%0d_w%0d", d, pnum[d]),
                                32'(len_c[d]), 32'(mon_e.len));
                            for (int c = 0; c < 4; c++)
                                chk($sformatf("hi_d%0d_w%0d_ch%0d", d, pnum[d], c),
                                    32'(hi_c[d][c]), 32'(mon_e.hi[c]));
                        end
                        pnum[d]++;
                    end
                    started[d] = 1;
                    len_c[d]   = 0;
                    for (int c = 0; c < 4; c++) hi_c[d][c] = 0;
                end
            end
        end
    end

    task automatic wait_ps(input int d);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!ps_w[d] && k < 5000);
        #1;
        chk($sformatf("ps_arrive_d%0d", d), 32'(ps_w[d]), 32'd1);
    endtask

    task automatic tick_in;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int idle_hi;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pwm", 32'(pwm1), 32'd0);
        chk("rst_pending", 32'(pend1), 32'd0);
        chk("rst_period_start", 32'(ps1), 32'd0);
        rst1 = 1'b0;

        idle_hi = 0;
        repeat (200) begin
            @(negedge clock);
            if (pwm1 != 4'd0) idle_hi++;
        end
        chk("idle_no_pulse", 32'(idle_hi), 32'd0);

        // Basic pulse: ch0=10 -> 74, ch1=0 -> 64
        wait_ps(0);
        w = pnum[0];
        tick_in(); wr1 = 1'b1; sel1 = 2'd0; duty1 = 8'd10;
        tick_in(); sel1 = 2'd1; duty1 = 8'd0;
        tick_in(); wr1 = 1'b0; en1 = 4'b0011; commit1 = 1'b1;
        tick_in(); commit1 = 1'b0;
        chk("pending_set", 32'(pend1), 32'd1);
        expect_win(0, w,     100, 0,  0,  0, 0);
        expect_win(0, w + 1, 100, 74, 64, 0, 0);
        expect_win(0, w + 2, 100, 74, 64, 0, 0);
        wait_ps(0);
        chk("pending_clear", 32'(pend1), 32'd0);

        // Mid-period update at counter 30 lands one period later
        wait_ps(0);
        repeat (30) @(posedge clock);
        #1;
        wr1 = 1'b1; sel1 = 2'd0; duty1 = 8'd30; commit1 = 1'b1;
        tick_in(); wr1 = 1'b0; commit1 = 1'b0;
        expect_win(0, w + 3, 100, 94, 64, 0, 0);

        // Commit on the boundary cycle waits one extra period
        wait_ps(0);
        repeat (99) @(posedge clock);
        #1;
        wr1 = 1'b1; sel1 = 2'd1; duty1 = 8'd20; commit1 = 1'b1;
        tick_in(); wr1 = 1'b0; commit1 = 1'b0;
        chk("bnd_period_start", 32'(ps1), 32'd1);
        chk("bnd_pending_held", 32'(pend1), 32'd1);
        expect_win(0, w + 4, 100, 94, 64, 0, 0);
        expect_win(0, w + 5, 100, 94, 84, 0, 0);
        wait_ps(0);
        wait_ps(0);
        chk("bnd_pending_clear", 32'(pend1), 32'd0);

        // Shorter period: every pulse now covers the whole period
        tick_in(); en1 = 4'b1111; end1 = 12'd49; commit1 = 1'b1;
        tick_in(); commit1 = 1'b0;
        expect_win(0, w + 6, 50, 50, 50, 50, 50);
        expect_win(0, w + 7, 50, 50, 50, 50, 50);
        repeat (3) wait_ps(0);
        rst1 = 1'b1;

        // Slew 4: 64, 68, 72, 74, 74; out-of-range select ignored
        tick_in(); rst2 = 1'b0;
        wait_ps(1);
        w = pnum[1];
        tick_in(); wr2 = 1'b1; sel2 = 2'd0; duty2 = 8'd10;
        tick_in(); sel2 = 2'd3; duty2 = 8'd200;
        tick_in(); wr2 = 1'b0; en2 = 3'b111; commit2 = 1'b1;
        tick_in(); commit2 = 1'b0;
        expect_win(1, w,     100, 0,  0,  0,  0);
        expect_win(1, w + 1, 100, 64, 64, 64, 0);
        expect_win(1, w + 2, 100, 68, 64, 64, 0);
        expect_win(1, w + 3, 100, 72, 64, 64, 0);
        expect_win(1, w + 4, 100, 74, 64, 64, 0);
        expect_win(1, w + 5, 100, 74, 64, 64, 0);
        repeat (6) wait_ps(1);
        rst2 = 1'b1;

        // Prescaled period of 391*4 clocks, then reset mid-period
        tick_in(); rst3 = 1'b0;
        wait_ps(2);
        w = pnum[2];
        expect_win(2, w, 1564, 0, 0, 0, 0);
        tick_in(); wr3 = 1'b1; sel3 = 2'd0; duty3 = 8'd0;
        tick_in(); wr3 = 1'b0; en3 = 4'b0001; commit3 = 1'b1;
        tick_in(); commit3 = 1'b0;
        expect_win(2, w + 1, 1564, 1564, 0, 0, 0);
        repeat (2) wait_ps(2);
        repeat (700) @(posedge clock);
        #1;
        chk("pre_reset_pwm", 32'(pwm3), 32'd1);
        rst3 = 1'b1;
        tick_in();
        chk("mid_reset_pwm", 32'(pwm3), 32'd0);
        chk("mid_reset_ps", 32'(ps3), 32'd0);
        chk("mid_reset_pending", 32'(pend3), 32'd0);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
